// File: rtl/iex_result_stage_pkg.sv
// Shared definitions for the IEX result stage: default widths, skid-buffer state encoding
// and the layout of one buffered result entry.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package iex_result_stage_pkg;

  localparam int DATA_WIDTH_DEFAULT     = `DATA_WIDTH;
  localparam int REG_ADDR_WIDTH_DEFAULT = 5;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_e;

  // One entry as stored in the skid buffer, packed as {data, rd_addr, wr_en}.
  typedef struct packed {
    logic [DATA_WIDTH_DEFAULT-1:0]     data;
    logic [REG_ADDR_WIDTH_DEFAULT-1:0] rd_addr;
    logic                              wr_en;
  } result_entry_t;

  function automatic int entry_width(input int data_w, input int addr_w);
    return data_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/iex_result_stage_skid_buf2.sv
// iex_skid_buf2: generic 2-entry valid/ready buffer with synchronous flush.
// The ready output decodes registered state only, so there is no path from out_rdy to in_rdy.
module iex_skid_buf2
  import iex_result_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data,
  output buf_state_e   state
);

  // Handshake: a transfer happens on a clock edge where vld and rdy are both high;
  // a producer holding vld keeps its data stable until that edge.
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         push;
  logic         pop;

  assign in_rdy   = (state != BUF_FULL);
  assign out_vld  = (state != BUF_EMPTY);
  assign out_data = head_q;
  assign push     = in_vld & in_rdy;
  assign pop      = out_vld & out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BUF_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      state <= BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (push) begin
            head_q <= in_data;
            state  <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (push && pop) begin
            head_q <= in_data;
          end else if (push) begin
            tail_q <= in_data;
            state  <= BUF_FULL;
          end else if (pop) begin
            state  <= BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          // The second entry becomes head; no push can land here since in_rdy is low.
          if (pop) begin
            head_q <= tail_q;
            state  <= BUF_ONE;
          end
        end
        default: state <= BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/iex_result_stage.sv
// iex_result_stage: merges the ALU plane results, tags them with rd and buffers them for MEM.
// Optional macro IEX_RESULT_FWD_EN adds the operand-bypass outputs fwd_vld/fwd_rd_addr/fwd_data.
module iex_result_stage
  import iex_result_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iex_in_vld,
  output logic                      iex_in_rdy,
  input  logic [REG_ADDR_WIDTH-1:0] iex_rd_addr,
  input  logic                      iex_rd_wr_en,
  input  logic [DATA_WIDTH-1:0]     logic_plane_data_out,
  input  logic                      logic_plane_output_vld,
  input  logic [DATA_WIDTH-1:0]     arith_plane_data_out,
  input  logic                      arith_plane_output_vld,
  input  logic [DATA_WIDTH-1:0]     shift_plane_data_out,
  input  logic                      shift_plane_output_vld,
  input  logic                      flush,
  output logic                      mem_out_vld,
  input  logic                      mem_out_rdy,
  output logic [DATA_WIDTH-1:0]     mem_out_data,
  output logic [REG_ADDR_WIDTH-1:0] mem_out_rd_addr,
  output logic                      mem_out_rd_wr_en,
  output logic                      plane_sel_err,
  output buf_state_e                buf_state
`ifdef IEX_RESULT_FWD_EN
  ,
  output logic                      fwd_vld,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd_addr,
  output logic [DATA_WIDTH-1:0]     fwd_data
`endif
);

  localparam int ENTRY_W = entry_width(DATA_WIDTH, REG_ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] merged;
  logic                  rd_wr_en;
  logic                  push;
  logic                  multi_vld;
  logic [ENTRY_W-1:0]    in_entry;
  logic [ENTRY_W-1:0]    head_entry;

  // Planes are expected to be one-hot; no plane valid yields 0 for non-ALU instructions.
  assign merged = (logic_plane_data_out & {DATA_WIDTH{logic_plane_output_vld}})
                | (arith_plane_data_out & {DATA_WIDTH{arith_plane_output_vld}})
                | (shift_plane_data_out & {DATA_WIDTH{shift_plane_output_vld}});

  // x0 is hard-wired zero, so a write to it is dropped at capture.
  assign rd_wr_en  = iex_rd_wr_en & (iex_rd_addr != '0);
  assign in_entry  = {merged, iex_rd_addr, rd_wr_en};
  assign push      = iex_in_vld & iex_in_rdy;
  assign multi_vld = (logic_plane_output_vld & arith_plane_output_vld)
                   | (logic_plane_output_vld & shift_plane_output_vld)
                   | (arith_plane_output_vld & shift_plane_output_vld);

  iex_skid_buf2 #(
    .W(ENTRY_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_vld   (iex_in_vld),
    .in_rdy   (iex_in_rdy),
    .in_data  (in_entry),
    .out_vld  (mem_out_vld),
    .out_rdy  (mem_out_rdy),
    .out_data (head_entry),
    .state    (buf_state)
  );

  assign {mem_out_data, mem_out_rd_addr, mem_out_rd_wr_en} = head_entry;

  // Sticky until reset; a flush does not hide a plane-select fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plane_sel_err <= 1'b0;
    end else if (push && multi_vld) begin
      plane_sel_err <= 1'b1;
    end
  end

`ifdef IEX_RESULT_FWD_EN
  assign fwd_vld     = mem_out_vld & mem_out_rd_wr_en;
  assign fwd_rd_addr = mem_out_rd_addr;
  assign fwd_data    = mem_out_data;
`endif

endmodule

// File: tb/tb_iex_result_stage.sv
// Self-checking bench for iex_result_stage: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_iex_result_stage;
  import iex_result_stage_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int EW = DW + AW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          iex_in_vld = 0, iex_in_rdy;
  logic [AW-1:0] iex_rd_addr = '0;
  logic          iex_rd_wr_en = 0;
  logic [DW-1:0] ld = '0, ad = '0, sd = '0;
  logic          lv = 0, av = 0, sv = 0;
  logic          flush = 0;
  logic          mem_out_vld, mem_out_rdy = 0;
  logic [DW-1:0] mem_out_data;
  logic [AW-1:0] mem_out_rd_addr;
  logic          mem_out_rd_wr_en;
  logic          plane_sel_err;
  buf_state_e    buf_state;
`ifdef IEX_RESULT_FWD_EN
  logic          fwd_vld;
  logic [AW-1:0] fwd_rd_addr;
  logic [DW-1:0] fwd_data;
`endif

  iex_result_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .iex_in_vld             (iex_in_vld),
    .iex_in_rdy             (iex_in_rdy),
    .iex_rd_addr            (iex_rd_addr),
    .iex_rd_wr_en           (iex_rd_wr_en),
    .logic_plane_data_out   (ld),
    .logic_plane_output_vld (lv),
    .arith_plane_data_out   (ad),
    .arith_plane_output_vld (av),
    .shift_plane_data_out   (sd),
    .shift_plane_output_vld (sv),
    .flush                  (flush),
    .mem_out_vld            (mem_out_vld),
    .mem_out_rdy            (mem_out_rdy),
    .mem_out_data           (mem_out_data),
    .mem_out_rd_addr        (mem_out_rd_addr),
    .mem_out_rd_wr_en       (mem_out_rd_wr_en),
    .plane_sel_err          (plane_sel_err),
    .buf_state              (buf_state)
`ifdef IEX_RESULT_FWD_EN
    ,
    .fwd_vld                (fwd_vld),
    .fwd_rd_addr            (fwd_rd_addr),
    .fwd_data               (fwd_data)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];   // {data, rd, wr_en}, head at index 0
  logic          exp_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a bounded FIFO of depth 2; flush empties it, push/pop follow the handshake.
  task automatic model_edge();
    logic [DW-1:0] res;
    bit push, pop;
    res = '0;
    if (lv) res = res | ld;
    if (av) res = res | ad;
    if (sv) res = res | sd;
    push = iex_in_vld && (exp_q.size() < 2);
    pop  = (exp_q.size() > 0) && mem_out_rdy;
    if (push && (int'(lv) + int'(av) + int'(sv) >= 2)) exp_err = 1'b1;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({res, iex_rd_addr, iex_rd_wr_en && (iex_rd_addr != 0)});
    end
  endtask

  task automatic compare_all(input string tag);
    logic [EW-1:0] h;
    logic [1:0] st;
    st = (exp_q.size() == 0) ? 2'b00 : (exp_q.size() == 1) ? 2'b01 : 2'b10;
    check({tag, ".mem_out_vld"}, 64'(mem_out_vld), 64'(exp_q.size() > 0));
    check({tag, ".iex_in_rdy"}, 64'(iex_in_rdy), 64'(exp_q.size() < 2));
    check({tag, ".state"}, 64'(buf_state), 64'(st));
    check({tag, ".plane_sel_err"}, 64'(plane_sel_err), 64'(exp_err));
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      check({tag, ".data"}, 64'(mem_out_data), 64'(h[EW-1 -: DW]));
      check({tag, ".rd_addr"}, 64'(mem_out_rd_addr), 64'(h[AW:1]));
      check({tag, ".wr_en"}, 64'(mem_out_rd_wr_en), 64'(h[0]));
`ifdef IEX_RESULT_FWD_EN
      check({tag, ".fwd_vld"}, 64'(fwd_vld), 64'(h[0]));
      check({tag, ".fwd_data"}, 64'(fwd_data), 64'(h[EW-1 -: DW]));
      check({tag, ".fwd_rd"}, 64'(fwd_rd_addr), 64'(h[AW:1]));
`endif
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".vld"}, 64'(mem_out_vld), 64'(0));
    check({tag, ".data"}, 64'(mem_out_data), 64'(0));
    check({tag, ".rd"}, 64'(mem_out_rd_addr), 64'(0));
    check({tag, ".wr"}, 64'(mem_out_rd_wr_en), 64'(0));
    check({tag, ".err"}, 64'(plane_sel_err), 64'(0));
    check({tag, ".rdy"}, 64'(iex_in_rdy), 64'(1));
    check({tag, ".state"}, 64'(buf_state), 64'(0));
`ifdef IEX_RESULT_FWD_EN
    check({tag, ".fwd_vld"}, 64'(fwd_vld), 64'(0));
    check({tag, ".fwd_data"}, 64'(fwd_data), 64'(0));
    check({tag, ".fwd_rd"}, 64'(fwd_rd_addr), 64'(0));
`endif
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic l_v, input logic [DW-1:0] l_d, input logic a_v, input logic [DW-1:0] a_d,
                       input logic s_v, input logic [DW-1:0] s_d, input logic in_v, input logic [AW-1:0] rd,
                       input logic wr, input logic rdy, input logic fl);
    lv = l_v; ld = l_d; av = a_v; ad = a_d; sv = s_v; sd = s_d;
    iex_in_vld = in_v; iex_rd_addr = rd; iex_rd_wr_en = wr; mem_out_rdy = rdy; flush = fl;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          lv, av, sv;
    logic [DW-1:0] data;
    logic          in_vld;
    logic [AW-1:0] rd;
    logic          wr, rdy, fl;
    logic          e_vld;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_rd;
    logic          e_wr, e_in_rdy;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic l_v, input logic a_v, input logic s_v, input logic [DW-1:0] d,
                         input logic in_v, input logic [AW-1:0] rd, input logic wr, input logic rdy,
                         input logic fl, input logic e_vld, input logic [DW-1:0] e_d,
                         input logic [AW-1:0] e_rd, input logic e_wr, input logic e_in_rdy);
    vec_t v;
    v.lv = l_v; v.av = a_v; v.sv = s_v; v.data = d; v.in_vld = in_v; v.rd = rd; v.wr = wr;
    v.rdy = rdy; v.fl = fl; v.e_vld = e_vld; v.e_data = e_d; v.e_rd = e_rd; v.e_wr = e_wr;
    v.e_in_rdy = e_in_rdy;
    vecs.push_back(v);
  endtask

  initial begin
    // Single push, one-cycle latency, then drain
    add_vec(1,0,0, 32'h0000_00FF, 1, 5, 1, 1, 0,   1, 32'h0000_00FF, 5, 1, 1);
    add_vec(0,0,0, 32'h0,         0, 0, 0, 1, 0,   0, 32'h0,         0, 0, 1);
    // Backpressure: A then B fill the buffer, then drain in order
    add_vec(0,1,0, 32'h1,         1, 1, 1, 0, 0,   1, 32'h1,         1, 1, 1);
    add_vec(0,1,0, 32'h2,         1, 2, 1, 0, 0,   1, 32'h1,         1, 1, 0);
    add_vec(0,0,0, 32'h0,         0, 0, 0, 1, 0,   1, 32'h2,         2, 1, 1);
    add_vec(0,0,0, 32'h0,         0, 0, 0, 1, 0,   0, 32'h0,         0, 0, 1);
    // ONE with simultaneous push C and pop: C becomes head
    add_vec(0,0,1, 32'h4,         1, 3, 1, 0, 0,   1, 32'h4,         3, 1, 1);
    add_vec(0,1,0, 32'h3,         1, 4, 1, 1, 0,   1, 32'h3,         4, 1, 1);
    add_vec(0,0,0, 32'h0,         0, 0, 0, 1, 0,   0, 32'h0,         0, 0, 1);
    // rd=0 never writes; fill to FULL then flush with rdy high
    add_vec(1,0,0, 32'h7,         1, 0, 1, 0, 0,   1, 32'h7,         0, 0, 1);
    add_vec(1,0,0, 32'h8,         1, 6, 0, 0, 0,   1, 32'h7,         0, 0, 0);
    add_vec(1,0,0, 32'h9,         1, 9, 1, 1, 1,   0, 32'h0,         0, 0, 1);
    add_vec(0,1,0, 32'hA,         1, 7, 1, 1, 0,   1, 32'hA,         7, 1, 1);
    add_vec(0,0,0, 32'h0,         0, 0, 0, 1, 0,   0, 32'h0,         0, 0, 1);
    // No plane valid merges to 0; flush beats a same-cycle push
    add_vec(0,0,0, 32'h55,        1, 8, 1, 1, 0,   1, 32'h0,         8, 1, 1);
    add_vec(0,0,0, 32'h0,         0, 0, 0, 1, 0,   0, 32'h0,         0, 0, 1);
    add_vec(1,0,0, 32'hB,         1, 9, 1, 1, 1,   0, 32'h0,         0, 0, 1);

    // Reset values, held in reset across two edges
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].lv, vecs[i].data, vecs[i].av, vecs[i].data, vecs[i].sv, vecs[i].data,
            vecs[i].in_vld, vecs[i].rd, vecs[i].wr, vecs[i].rdy, vecs[i].fl);
      tick(tag);
      check({tag, ".t_vld"}, 64'(mem_out_vld), 64'(vecs[i].e_vld));
      check({tag, ".t_in_rdy"}, 64'(iex_in_rdy), 64'(vecs[i].e_in_rdy));
      if (vecs[i].e_vld) begin
        check({tag, ".t_data"}, 64'(mem_out_data), 64'(vecs[i].e_data));
        check({tag, ".t_rd"}, 64'(mem_out_rd_addr), 64'(vecs[i].e_rd));
        check({tag, ".t_wr"}, 64'(mem_out_rd_wr_en), 64'(vecs[i].e_wr));
      end
    end

    // Two planes valid on an accepted push sets the sticky error; flush leaves it set
    drive(0, 32'h0, 1, 32'h10, 1, 32'h01, 1, 3, 1, 0, 0);
    tick("err_push");
    check("err_set", 64'(plane_sel_err), 64'(1));
    check("err_merge", 64'(mem_out_data), 64'(32'h11));
    drive(1, 32'h20, 0, 32'h0, 0, 32'h0, 1, 4, 1, 0, 0);
    tick("err_fill");
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1, 1);
    tick("err_flush");
    check("err_after_flush", 64'(plane_sel_err), 64'(1));
    drive(1, 32'h30, 0, 32'h0, 0, 32'h0, 1, 5, 1, 0, 0);
    tick("pre_rst0");
    drive(1, 32'h31, 0, 32'h0, 0, 32'h0, 1, 6, 1, 0, 0);
    tick("pre_rst1");

    // Asynchronous reset mid-cycle with the buffer FULL
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    exp_q.delete();
    exp_err = 1'b0;
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      int mode;
      mode = $urandom_range(0, 7);
      drive(mode == 1 || mode == 2 || (mode == 7 && $urandom_range(0, 1) == 1), $urandom(),
            mode == 3 || mode == 4 || (mode == 7 && $urandom_range(0, 1) == 1), $urandom(),
            mode == 5 || mode == 6 || (mode == 7 && $urandom_range(0, 1) == 1), $urandom(),
            $urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      tick($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
